// File: rtl/mul_fp_pipelined.sv
// Three-stage pipelined floating-point multiplier (DAZ inputs, FTZ results, RNE/RTZ rounding)
// with valid/ready backpressure, per-result exception flags and an opaque passthrough tag.
module mul_fp_pipelined #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 rnd_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           flags
);
  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int PW      = 2 * MAN_W + 2;
  localparam int XW      = EXP_W + 2;
  localparam int BIAS    = 2 ** (EXP_W - 1) - 1;
  localparam int EXP_TOP = 2 ** EXP_W - 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_MAXF = EXP_W'(EXP_TOP - 1);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign ea     = a[W-2:MAN_W];
  assign eb     = b[W-2:MAN_W];
  assign ma     = a[MAN_W-1:0];
  assign mb     = b[MAN_W-1:0];
  // exponent field 0 covers both true zero and subnormals (denormals-are-zero)
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);

  logic                 s1_valid, s1_sign, s1_nan, s1_snan, s1_inf, s1_zero, s1_rnd;
  logic [MAN_W:0]       s1_ma, s1_mb;
  logic signed [XW-1:0] s1_exp;
  logic [TAG_W-1:0]     s1_tag;

  logic                 s2_valid, s2_sign, s2_nan, s2_snan, s2_inf, s2_zero, s2_rnd;
  logic [PW-1:0]        s2_prod;
  logic signed [XW-1:0] s2_exp;
  logic [TAG_W-1:0]     s2_tag;

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sign <= a[W-1] ^ b[W-1];
      s1_nan  <= a_nan || b_nan;
      s1_snan <= (a_nan && !ma[MAN_W-1]) || (b_nan && !mb[MAN_W-1]);
      s1_inf  <= a_inf || b_inf;
      s1_zero <= a_zero || b_zero;
      s1_ma   <= {1'b1, ma};
      s1_mb   <= {1'b1, mb};
      s1_exp  <= XW'({2'b00, ea}) + XW'({2'b00, eb}) - XW'(BIAS);
      s1_rnd  <= rnd_mode;
      s1_tag  <= in_tag;

      s2_sign <= s1_sign;
      s2_nan  <= s1_nan;
      s2_snan <= s1_snan;
      s2_inf  <= s1_inf;
      s2_zero <= s1_zero;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      s2_exp  <= s1_exp;
      s2_rnd  <= s1_rnd;
      s2_tag  <= s1_tag;
    end
  end

  logic                 norm, guard, sticky, inc, carry;
  logic [MAN_W-1:0]     frac, frac_r;
  logic signed [XW-1:0] exp_n, exp_r;
  logic [W-1:0]         res_d;
  logic [3:0]           flags_d;

  always_comb begin
    norm = s2_prod[PW-1];
    if (norm) begin
      frac   = s2_prod[PW-2 -: MAN_W];
      guard  = s2_prod[MAN_W];
      sticky = |s2_prod[MAN_W-1:0];
    end else begin
      frac   = s2_prod[PW-3 -: MAN_W];
      guard  = s2_prod[MAN_W-1];
      sticky = |s2_prod[MAN_W-2:0];
    end
    exp_n           = s2_exp + XW'(norm);
    inc             = !s2_rnd && guard && (sticky || frac[0]);
    // an all-ones fraction rounding up wraps to zero and bumps the exponent
    {carry, frac_r} = {1'b0, frac} + (MAN_W+1)'(inc);
    exp_r           = exp_n + XW'(carry);

    res_d   = {s2_sign, exp_r[EXP_W-1:0], frac_r};
    flags_d = {3'b000, guard || sticky};

    if (s2_nan) begin
      res_d   = QNAN;
      flags_d = {s2_snan, 3'b000};
    end else if (s2_inf && s2_zero) begin
      res_d   = QNAN;
      flags_d = 4'b1000;
    end else if (s2_inf) begin
      res_d   = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 4'b0000;
    end else if (s2_zero) begin
      res_d   = {s2_sign, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if (exp_r >= EXP_TOP) begin
      res_d   = s2_rnd ? {s2_sign, EXP_MAXF, {MAN_W{1'b1}}} : {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (exp_r <= 0) begin
      res_d   = {s2_sign, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      flags     <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        result  <= res_d;
        out_tag <= s2_tag;
        flags   <= flags_d;
      end
    end
  end

endmodule
